fetcher: RTL
============

// Module: fetcher
// PURPOSE
//  Per-core instruction fetch stage; sits directly upstream of the decoder.
//  - On the core's FETCH phase, reads the 16-bit word at current_pc from program memory.
//  - Uses a valid/ready read port, registers the returned word, and holds it stable for the decoder's DECODE cycle.
//  - Bounds memory latency with a timeout that substitutes HALT.
// PARAMETERS
//  PROGRAM_ADDR_BITS  8    program memory address / PC width
//  PROGRAM_DATA_BITS  16   instruction width
//  FETCH_TIMEOUT      255  max FETCHING cycles without ready before ERROR; 0 = disabled
// PORTS
//  clk               in   1                  core clock
//  reset             in   1                  synchronous, active-low reset
//  core_state        in   3                  core phase (core_pkg::core_state_t)
//  current_pc        in   PROGRAM_ADDR_BITS  PC of instruction to fetch
//  mem_read_valid    out  1                  read request to program memory
//  mem_read_address  out  PROGRAM_ADDR_BITS  read address, registered
//  mem_read_ready    in   1                  memory returns data this cycle
//  mem_read_data     in   PROGRAM_DATA_BITS  returned instruction word
//  fetcher_state     out  3                  IDLE=0, FETCHING=1, FETCHED=2, ERROR=3
//  instruction       out  PROGRAM_DATA_BITS  registered instruction to decoder
//  instr_valid       out  1                  instruction holds a completed fetch
//  fetch_error       out  1                  sticky timeout flag
// BEHAVIOUR
//  Clocking and reset
//  - All state updates on posedge clk. Only posedge clk edges with reset==0 clear state.
//  - Reset values: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, instr_valid=0,
//    fetch_error=0, timeout counter=0.
//  State machine
//  - IDLE: if core_state==CORE_FETCH, next cycle enter FETCHING, assert mem_read_valid, latch
//    mem_read_address<=current_pc, clear counter; else stay. Ready in IDLE is ignored.
//  - FETCHING: valid and address held stable until ready (PC changes ignored).
//    - On ready: instruction<=mem_read_data, valid drops, instr_valid=1, enter FETCHED.
//      Minimum latency is 2 edges from the CORE_FETCH sample to instr_valid.
//    - Each non-ready cycle increments the counter (saturating, width $clog2(FETCH_TIMEOUT+1)).
//    - When counter==FETCH_TIMEOUT-1 and no ready: enter ERROR, drop valid,
//      instruction<=16'hF000 (HALT), instr_valid=1, fetch_error=1.
//    - Ready in the same cycle as the timeout: ready wins, normal fetch.
//  - FETCHED: instruction held. When core_state==CORE_DECODE, next cycle enter IDLE with instr_valid=0;
//    instruction is retained (not cleared). A new CORE_FETCH while FETCHED is ignored until IDLE is reached.
//  - ERROR: sticky until reset. Outputs frozen: instruction=HALT, instr_valid=1, valid=0.
//  Boundaries
//  - Reset asserted mid-FETCHING drops mem_read_valid on that edge; a late ready is ignored.
//  - current_pc at max address wraps nothing: address is passed through as-is.
//  - mem_read_data is sampled only on the ready cycle.
// STRUCTURE
//  - core_pkg: core_state_t (IDLE, FETCH, DECODE, REQUEST, WAIT, EXECUTE, UPDATE, DONE),
//    fetcher_state_t, OPC_HALT=4'hF, HALT_WORD=16'hF000. Shared with the decoder and scheduler.
//  - Single module, no sub-modules: one FSM always_ff plus next-state always_comb. Counter inline.
// TESTING
//  - Basic: core_state=FETCH, pc=8'h05, ready 3 cycles later with data=16'h3123
//    -> addr=05 held, valid high 3 cycles; instruction=3123, instr_valid=1, state=FETCHED.
//  - Zero-wait: ready in first FETCHING cycle, data=16'h9A07 -> instr_valid exactly 2 edges after
//    the FETCH sample; DECODE -> IDLE next cycle, instruction still 9A07.
//  - Stability: change current_pc 05->09 during FETCHING -> mem_read_address stays 05.
//  - Timeout: FETCH_TIMEOUT=4, ready never -> valid high 4 cycles, then state=ERROR,
//    instruction=F000, fetch_error=1; stays until reset.
//  - Race: ready on the timeout cycle -> FETCHED with data, fetch_error=0.
//  - Reset: reset=0 mid-FETCHING, then ready -> all outputs zero, state=IDLE, ready ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: core phase encoding, fetcher state encoding and
// the HALT instruction word. Used by the fetcher, decoder and scheduler.
package core_pkg;

  // Core pipeline phase driven by the scheduler.
  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  // Fetcher FSM encoding, also exported as a debug/status output.
  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'd0,
    FETCHER_FETCHING = 3'd1,
    FETCHER_FETCHED  = 3'd2,
    FETCHER_ERROR    = 3'd3
  } fetcher_state_t;

  localparam logic [3:0]  OPC_HALT  = 4'hF;
  localparam logic [15:0] HALT_WORD = {OPC_HALT, 12'h000};

endpackage

// File: rtl/fetcher.sv
// Instruction fetch stage sitting directly upstream of the decoder.
// On CORE_FETCH it issues a read of current_pc to program memory, captures
// the returned word and holds it for the decoder until CORE_DECODE. A memory
// that never answers is bounded by a timeout that substitutes HALT and parks
// the fetcher in a sticky ERROR state.
//
// Memory handshake: mem_read_valid is high for the whole time the fetcher is
// in FETCHING, with mem_read_address held constant; the transfer completes on
// the first rising clk edge where mem_read_valid and mem_read_ready are both
// high, and mem_read_data is sampled only on that edge. Ready outside
// FETCHING is ignored.
//
// Ports:
//   clk, reset        core clock, synchronous active-low reset
//   core_state        core phase from the scheduler
//   current_pc        PC of the instruction to fetch
//   mem_read_valid    read request to program memory
//   mem_read_address  registered read address
//   mem_read_ready    memory returns data this cycle
//   mem_read_data     returned instruction word
//   fetcher_state     FSM state (IDLE/FETCHING/FETCHED/ERROR)
//   instruction       registered instruction for the decoder
//   instr_valid       instruction holds a completed fetch (or HALT on error)
//   fetch_error       sticky timeout flag
module fetcher
  import core_pkg::*;
#(
  parameter int PROGRAM_ADDR_BITS = 8,
  parameter int PROGRAM_DATA_BITS = 16,
  parameter int FETCH_TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  core_state_t                  core_state,
  input  logic [PROGRAM_ADDR_BITS-1:0] current_pc,
  output logic                         mem_read_valid,
  output logic [PROGRAM_ADDR_BITS-1:0] mem_read_address,
  input  logic                         mem_read_ready,
  input  logic [PROGRAM_DATA_BITS-1:0] mem_read_data,
  output fetcher_state_t               fetcher_state,
  output logic [PROGRAM_DATA_BITS-1:0] instruction,
  output logic                         instr_valid,
  output logic                         fetch_error
);

  // A zero timeout disables the check; keep the counter at least 1 bit wide.
  localparam bit            TIMEOUT_EN = (FETCH_TIMEOUT != 0);
  localparam int            CW         = TIMEOUT_EN ? $clog2(FETCH_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST   = TIMEOUT_EN ? CW'(FETCH_TIMEOUT - 1) : '0;
  localparam logic [CW-1:0] CNT_MAX    = '1;

  fetcher_state_t               r_state,  w_state_nxt;
  logic [PROGRAM_ADDR_BITS-1:0] r_addr,   w_addr_nxt;
  logic [PROGRAM_DATA_BITS-1:0] r_instr,  w_instr_nxt;
  logic [CW-1:0]                r_count,  w_count_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= FETCHER_IDLE;
      r_addr  <= '0;
      r_instr <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_instr <= w_instr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_instr_nxt = r_instr;
    w_count_nxt = r_count;
    case (r_state)
      FETCHER_IDLE: begin
        if (core_state == CORE_FETCH) begin
          w_state_nxt = FETCHER_FETCHING;
          w_addr_nxt  = current_pc;
          w_count_nxt = '0;
        end
      end
      FETCHER_FETCHING: begin
        // Ready takes priority over a timeout landing on the same edge.
        if (mem_read_ready) begin
          w_instr_nxt = mem_read_data;
          w_state_nxt = FETCHER_FETCHED;
        end else if (TIMEOUT_EN && (r_count == CNT_LAST)) begin
          w_instr_nxt = PROGRAM_DATA_BITS'(HALT_WORD);
          w_state_nxt = FETCHER_ERROR;
        end else if (r_count != CNT_MAX) begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      FETCHER_FETCHED: begin
        // Instruction is retained on the way back to IDLE.
        if (core_state == CORE_DECODE) w_state_nxt = FETCHER_IDLE;
      end
      FETCHER_ERROR: begin
        w_state_nxt = FETCHER_ERROR;
      end
      default: begin
        w_state_nxt = FETCHER_IDLE;
      end
    endcase
  end

  // All outputs are decodes of registered state, so they change only on clk.
  assign mem_read_valid   = (r_state == FETCHER_FETCHING);
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign instr_valid      = (r_state == FETCHER_FETCHED) || (r_state == FETCHER_ERROR);
  assign fetch_error      = (r_state == FETCHER_ERROR);

endmodule
